// File: rtl/uart_pkg.sv
// Shared UART defaults and constant helpers used across the UART blocks.
package uart_pkg;

  localparam int unsigned DefaultCntW  = 16;
  localparam int unsigned DefaultFracW = 4;
  localparam int unsigned DefaultOvs   = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control/status bundle between a UART core and its fractional baud generator.
interface uart_baud_gen_frac_if
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W  = DefaultCntW,
  parameter int unsigned FRAC_W = DefaultFracW,
  parameter int unsigned OVS    = DefaultOvs
);
  localparam int unsigned PhW = clog2(OVS);

  logic              enable;
  logic [CNT_W-1:0]  baud_int;
  logic [FRAC_W-1:0] baud_frac;
  logic              cfg_load;
  logic              rx_resync;
  logic              cfg_ack;
  logic              baud_tick;
  logic              xmit_pulse;
  logic [PhW-1:0]    ovs_phase;

  modport master (
    output enable, baud_int, baud_frac, cfg_load, rx_resync,
    input  cfg_ack, baud_tick, xmit_pulse, ovs_phase
  );

  modport slave (
    input  enable, baud_int, baud_frac, cfg_load, rx_resync,
    output cfg_ack, baud_tick, xmit_pulse, ovs_phase
  );
endinterface

// File: rtl/uart_frac_acc.sv
// Fractional phase accumulator: a carry-out arms a one-cycle period stretch.
module uart_frac_acc #(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic              drop_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              stretch_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, frac_i};
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (clear_i) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (add_i) begin
      acc_d     = sum[FRAC_W-1:0];
      stretch_d = sum[FRAC_W];
    end else if (drop_i) begin
      // Stretch consumed by the hold cycle or discarded by a realign.
      stretch_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q     <= '0;
      stretch_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
    end
  end

  assign stretch_o = stretch_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator: oversample ticks, bit pulses and glitch-free
// divisor reconfiguration aligned to bit boundaries.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W  = DefaultCntW,
  parameter int unsigned FRAC_W = DefaultFracW,
  parameter int unsigned OVS    = DefaultOvs
) (
  input logic                 clk,
  input logic                 aresetn,
  uart_baud_gen_frac_if.slave bus
);

  localparam int unsigned PhW = clog2(OVS);

  logic [CNT_W-1:0]  cntr_q, cntr_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  shadow_int_q, shadow_int_d;
  logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
  logic [CNT_W-1:0]  active_int_q, active_int_d;
  logic [FRAC_W-1:0] active_frac_q, active_frac_d;
  logic              cfg_ack_q, cfg_ack_d;

  logic run, resync, zero, stretch, tick, xmit, hold, apply, acc_clear;

  // Outputs are forced quiet while reset is held, independent of enable.
  assign run    = bus.enable & aresetn;
  assign resync = run & bus.rx_resync;
  assign zero   = (cntr_q == '0);
  assign tick   = run & ~bus.rx_resync & zero & ~stretch;
  assign hold   = run & ~bus.rx_resync & zero & stretch;
  assign xmit   = tick & (phase_q == PhW'(OVS - 1));
  // While stopped there is no bit boundary to wait for, so apply at once.
  assign apply  = pending_q & (run ? xmit : 1'b1);
  assign acc_clear = ~run | apply;

  always_comb begin
    pending_d     = bus.cfg_load | (pending_q & ~apply);
    shadow_int_d  = bus.cfg_load ? bus.baud_int  : shadow_int_q;
    shadow_frac_d = bus.cfg_load ? bus.baud_frac : shadow_frac_q;
    active_int_d  = apply ? shadow_int_q  : active_int_q;
    active_frac_d = apply ? shadow_frac_q : active_frac_q;
    cfg_ack_d     = apply;

    cntr_d  = cntr_q;
    phase_d = phase_q;
    if (!run) begin
      cntr_d  = '0;
      phase_d = '0;
    end else if (bus.rx_resync) begin
      cntr_d  = active_int_q >> 1;
      phase_d = '0;
    end else if (tick) begin
      cntr_d  = apply ? shadow_int_q : active_int_q;
      phase_d = phase_q + PhW'(1);
    end else if (!hold) begin
      cntr_d  = cntr_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cntr_q        <= '0;
      phase_q       <= '0;
      pending_q     <= 1'b0;
      shadow_int_q  <= '0;
      shadow_frac_q <= '0;
      active_int_q  <= '0;
      active_frac_q <= '0;
      cfg_ack_q     <= 1'b0;
    end else begin
      cntr_q        <= cntr_d;
      phase_q       <= phase_d;
      pending_q     <= pending_d;
      shadow_int_q  <= shadow_int_d;
      shadow_frac_q <= shadow_frac_d;
      active_int_q  <= active_int_d;
      active_frac_q <= active_frac_d;
      cfg_ack_q     <= cfg_ack_d;
    end
  end

  uart_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk       (clk),
    .aresetn   (aresetn),
    .clear_i   (acc_clear),
    .add_i     (tick),
    .drop_i    (hold | resync),
    .frac_i    (active_frac_q),
    .stretch_o (stretch)
  );

  assign bus.baud_tick  = tick;
  assign bus.xmit_pulse = xmit;
  assign bus.ovs_phase  = phase_q;
  assign bus.cfg_ack    = cfg_ack_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: divisor table with an interval scoreboard, plus
// sequences for reconfiguration, realign, enable gating and reset.
module tb_uart_baud_gen_frac;
  import uart_pkg::*;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned OVS    = 16;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  uart_baud_gen_frac_if #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS)) bus ();

  uart_baud_gen_frac #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W),
    .OVS    (OVS)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct {
    int unsigned bint;
    int unsigned bfrac;
    int unsigned total;  // clocks spanned by 16 tick periods
  } vec_t;

  vec_t vecs[7];

  int unsigned tests = 0, fails = 0;
  int unsigned cyc = 0;
  int unsigned exp_q[$];
  bit          mon_en = 0;
  int unsigned tick_cnt, xmit_cnt, ack_cnt;
  int unsigned first_tick, last_tick, last_interval, tick_phase;
  int unsigned last_xmit_cyc, prev_xmit_cyc, last_ack_cyc;
  logic        s_tick, s_xmit, s_ack;
  logic [3:0]  s_phase;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample mid-cycle, update the monitor, return just after the next edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    s_tick = bus.baud_tick; s_xmit = bus.xmit_pulse;
    s_ack = bus.cfg_ack; s_phase = bus.ovs_phase;
    if (s_ack) begin ack_cnt++; last_ack_cyc = cyc; end
    if (s_xmit) begin
      check("xmit_with_tick", s_tick, 1);
      check("xmit_phase", s_phase, OVS - 1);
    end
    if (s_tick) begin
      if (tick_cnt > 0) begin
        last_interval = cyc - last_tick;
        if (mon_en && exp_q.size() > 0) check("tick_interval", last_interval, exp_q.pop_front());
      end else begin
        first_tick = cyc;
      end
      tick_cnt++;
      last_tick  = cyc;
      tick_phase = s_phase;
      if (s_xmit) begin
        xmit_cnt++;
        prev_xmit_cyc = last_xmit_cyc;
        last_xmit_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mon();
    tick_cnt = 0; xmit_cnt = 0;
    exp_q.delete();
  endtask

  task automatic load_cfg(input int unsigned bi, input int unsigned bf);
    bus.baud_int  = CNT_W'(bi);
    bus.baud_frac = FRAC_W'(bf);
    bus.cfg_load  = 1'b1;
    step();
    bus.cfg_load  = 1'b0;
  endtask

  // Stopped-generator load: ack expected two clocks after the load cycle.
  task automatic apply_idle(input int unsigned bi, input int unsigned bf);
    int unsigned c0;
    bus.enable = 1'b0;
    step();
    ack_cnt = 0;
    load_cfg(bi, bf);
    c0 = cyc;
    for (int i = 0; i < 10 && ack_cnt == 0; i++) step();
    check("idle_ack_seen", ack_cnt, 1);
    check("idle_ack_latency", last_ack_cyc - c0, 2);
  endtask

  task automatic run_ticks(input int unsigned n, input int unsigned budget);
    for (int unsigned i = 0; i < budget && tick_cnt < n; i++) step();
    check("ticks_seen", tick_cnt, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned a, carry, rc, tc, xc;

    vecs[0] = '{bint: 3, bfrac: 0,  total: 64};
    vecs[1] = '{bint: 3, bfrac: 8,  total: 72};
    vecs[2] = '{bint: 0, bfrac: 0,  total: 16};
    vecs[3] = '{bint: 2, bfrac: 5,  total: 53};
    vecs[4] = '{bint: 1, bfrac: 15, total: 47};
    vecs[5] = '{bint: 5, bfrac: 3,  total: 99};
    vecs[6] = '{bint: 0, bfrac: 4,  total: 20};

    bus.enable = 1'b1; bus.baud_int = '0; bus.baud_frac = '0;
    bus.cfg_load = 1'b0; bus.rx_resync = 1'b0;
    tick_cnt = 0; xmit_cnt = 0; ack_cnt = 0;
    last_xmit_cyc = 0; prev_xmit_cyc = 0; last_ack_cyc = 0;
    @(posedge clk); #1;

    // Reset state with enable held high.
    repeat (2) begin
      step();
      check("reset_outputs", {s_tick, s_xmit, s_ack, s_phase}, 0);
    end
    aresetn = 1'b1;
    reset_mon();
    step();
    check("post_reset_first_tick", s_tick, 1);
    check("post_reset_first_phase", tick_phase, 0);

    // Divisor table: per-period scoreboard plus total span over 16 periods.
    foreach (vecs[i]) begin
      apply_idle(vecs[i].bint, vecs[i].bfrac);
      reset_mon();
      a = 0;
      for (int k = 0; k < 16; k++) begin
        a = a + vecs[i].bfrac;
        carry = (a >= 16) ? 1 : 0;
        a = a % 16;
        exp_q.push_back(vecs[i].bint + 1 + carry);
      end
      mon_en = 1;
      bus.enable = 1'b1;
      run_ticks(17, 16 * (vecs[i].bint + 3) + 30);
      mon_en = 0;
      check("span_16_periods", last_tick - first_tick, vecs[i].total);
      check("xmit_per_16_ticks", xmit_cnt, 1);
    end

    // Running reconfiguration: two loads while pending, single ack at bit edge.
    apply_idle(3, 0);
    reset_mon();
    bus.enable = 1'b1;
    for (int i = 0; i < 300 && xmit_cnt < 2; i++) step();
    check("xmit_period", last_xmit_cyc - prev_xmit_cyc, 64);
    for (int i = 0; i < 80 && s_phase != 5; i++) step();
    check("phase5_reached", s_phase, 5);
    ack_cnt = 0;
    load_cfg(6, 0);
    step();
    load_cfg(7, 0);
    xc = xmit_cnt;
    for (int i = 0; i < 100 && xmit_cnt == xc; i++) step();
    check("no_ack_before_xmit", ack_cnt, 0);
    check("period_before_apply", last_interval, 4);
    for (int i = 0; i < 5 && ack_cnt == 0; i++) step();
    check("ack_after_xmit", last_ack_cyc - last_xmit_cyc, 1);
    tc = tick_cnt;
    for (int i = 0; i < 20 && tick_cnt == tc; i++) step();
    check("period_after_apply", last_interval, 8);
    repeat (40) step();
    check("single_ack", ack_cnt, 1);

    // Load coincident with an idle apply: both values get acknowledged in turn.
    bus.enable = 1'b0;
    step();
    ack_cnt = 0;
    load_cfg(5, 0);
    load_cfg(9, 0);
    repeat (4) step();
    check("coincident_load_acks", ack_cnt, 2);

    // Realign on the first enabled cycle overrides that cycle's tick.
    reset_mon();
    bus.enable = 1'b1;
    bus.rx_resync = 1'b1;
    step();
    bus.rx_resync = 1'b0;
    rc = cyc;
    check("resync_suppresses_tick", tick_cnt, 0);
    for (int i = 0; i < 20 && tick_cnt == 0; i++) step();
    check("resync_to_tick", last_tick - rc, 5);
    check("resync_tick_phase", tick_phase, 0);
    step();
    check("resync_phase_after", s_phase, 1);
    check("period_after_resync", 0, 0 + (tick_cnt == 1 ? 0 : 1));

    // Realign at an arbitrary point inside a bit.
    repeat ($urandom_range(3, 30)) step();
    bus.rx_resync = 1'b1;
    step();
    bus.rx_resync = 1'b0;
    rc = cyc;
    check("resync2_no_tick", s_tick, 0);
    tc = tick_cnt;
    for (int i = 0; i < 20 && tick_cnt == tc; i++) step();
    check("resync2_to_tick", last_tick - rc, 5);
    check("resync2_tick_phase", tick_phase, 0);
    tc = tick_cnt;
    for (int i = 0; i < 20 && tick_cnt == tc; i++) step();
    check("resync2_next_period", last_interval, 10);

    // Enable dropped mid-bit for 10 cycles.
    repeat (4) step();
    bus.enable = 1'b0;
    tc = tick_cnt;
    repeat (10) step();
    check("disabled_no_ticks", tick_cnt, tc);
    bus.enable = 1'b1;
    step();
    check("reenable_tick", s_tick, 1);
    check("reenable_tick_phase", tick_phase, 0);
    step();
    check("reenable_phase_after", s_phase, 1);

    // Reset mid-frame with a pending config: discarded, no ack afterwards.
    load_cfg(2, 0);
    repeat (3) step();
    aresetn = 1'b0;
    repeat (3) begin
      step();
      check("midrun_reset_outputs", {s_tick, s_xmit, s_ack, s_phase}, 0);
    end
    aresetn = 1'b1;
    reset_mon();
    ack_cnt = 0;
    step();
    check("post_reset2_first_tick", s_tick, 1);
    repeat (39) step();
    check("post_reset2_no_ack", ack_cnt, 0);
    check("post_reset2_tick_every_cycle", tick_cnt, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen_frac.md
UART_BAUD_GEN_FRAC -- requirements
Module: uart_baud_gen_frac

Interface
REQ-001 Parameter CNT_W, default 16: integer divider width, 4..24.
REQ-002 Parameter FRAC_W, default 4: fractional divider width, 1..8.
REQ-003 Parameter OVS, default 16: oversample ticks per bit; power of two, 4..32.
REQ-004 Port clk  in  1: system clock.
REQ-005 Port aresetn  in  1: reset, asynchronous, active-low.
REQ-006 Port enable  in  1: generator run; low holds the generator cleared.
REQ-007 Port baud_int  in  CNT_W: integer divisor; tick period is baud_int+1 clocks.
REQ-008 Port baud_frac  in  FRAC_W: fractional divisor, units of 1/2^FRAC_W clock.
REQ-009 Port cfg_load  in  1: one-cycle request to capture baud_int/baud_frac.
REQ-010 Port rx_resync  in  1: one-cycle realign pulse on a receiver start-bit edge.
REQ-011 Port cfg_ack  out  1: one-cycle pulse when captured config becomes active.
REQ-012 Port baud_tick  out  1: one-cycle oversample tick (OVS per bit).
REQ-013 Port xmit_pulse  out  1: one-cycle bit-rate pulse.
REQ-014 Port ovs_phase  out  log2(OVS): current oversample count.

Function
REQ-015 Down-counter cntr SHALL decrement each enabled cycle; at 0 it SHALL reload active_int and assert baud_tick for that cycle.
REQ-016 Each baud_tick SHALL add active_frac to FRAC_W-bit accumulator acc (mod 2^FRAC_W); a carry-out SHALL set flag stretch.
REQ-017 When cntr==0 and stretch==1, cntr SHALL hold for one cycle with no tick and stretch SHALL clear; the tick SHALL occur the following cycle.
REQ-018 Long-run mean tick period SHALL equal baud_int+1+baud_frac/2^FRAC_W clocks exactly.
REQ-019 baud_int=0, baud_frac=0 SHALL tick every enabled cycle.
REQ-020 ovs_phase SHALL increment (mod OVS) on each baud_tick; xmit_pulse SHALL assert on the tick where ovs_phase==OVS-1 (same cycle as that tick).
REQ-021 cfg_load SHALL copy baud_int/baud_frac into a shadow register and set pending; later cfg_load while pending SHALL overwrite the shadow and produce one ack only.
REQ-022 With enable high, pending config SHALL become active in the cycle of the next xmit_pulse; cntr SHALL reload from the new value and acc/stretch SHALL clear; cfg_ack SHALL pulse the following cycle.
REQ-023 With enable low, pending config SHALL become active the cycle after cfg_load, cfg_ack the next cycle.
REQ-024 cfg_load coincident with an apply SHALL apply the old shadow, capture the new value, and leave pending set.
REQ-025 rx_resync SHALL load cntr with active_int>>1, set ovs_phase to 0, clear stretch, suppress baud_tick/xmit_pulse that cycle; acc is retained; rx_resync overrides a coincident tick.
REQ-026 enable low SHALL force cntr=0, ovs_phase=0, acc=0, stretch=0, baud_tick=xmit_pulse=0; the first tick SHALL occur on the first enabled cycle.

Reset
REQ-027 On aresetn low: cntr, acc, stretch, ovs_phase, pending, cfg_ack, baud_tick, xmit_pulse SHALL be 0; active_int/active_frac SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard pending config without a cfg_ack.

Structure
REQ-029 Shared package uart_pkg SHALL hold OVS/CNT_W/FRAC_W defaults and a function clog2.
REQ-030 One sub-module uart_frac_acc (accumulator + stretch flag) SHALL be instantiated; the rest is flat.

Verification
REQ-031 baud_int=3, frac=0, OVS=16: baud_tick every 4 clocks; xmit_pulse every 64 clocks.
REQ-032 baud_int=3, frac=8, FRAC_W=4: tick periods alternate 4,5; 16 ticks in 72 clocks.
REQ-033 Running baud_int=3; cfg_load baud_int=7 at ovs_phase=5: old period kept until next xmit_pulse; cfg_ack one cycle later; then period 8.
REQ-034 rx_resync at arbitrary phase with baud_int=9: no tick that cycle; next tick 5 clocks later with ovs_phase 0->1.
REQ-035 aresetn low mid-frame with pending set: all outputs 0, no cfg_ack after release; enable high gives first tick next cycle.
REQ-036 enable low for 10 cycles mid-bit: no ticks; re-enable gives tick on first cycle with ovs_phase 0->1.
